mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `FastMult` instance (4x4 unsigned combinational multiplier, 8-bit product) among `N` requesters. It accepts one operand pair per transaction through a per-requester valid/ready handshake and registers the operands into the shared multiplier. It returns the registered product, tagged with the requester index, on a single response channel with backpressure. It sits between client blocks and the multiplier so that only one multiplier is instantiated.

---
 rtl/mult_arbiter.sv | 151 +++++++++++++++
 tb/tb_mult_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end that shares one 4x4 multiplier among
// N requesters.
//
// Each transaction is one operand pair. The arbiter takes one transaction at a
// time: it registers the operands, registers the product one cycle later, and
// then holds a tagged response until the consumer accepts it.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   req_valid   [N]    requester i presents operands
//   req_lhs     [4N]   requester i left operand at [4i+3:4i]
//   req_rhs     [4N]   requester i right operand at [4i+3:4i]
//   req_ready   [N]    one-hot grant, only asserted in IDLE
//   resp_valid  response holds a product
//   resp_id     [IDW]  index of the requester that owns the response
//   resp_data   [8]    unsigned product, zero-extended
//   resp_ready  consumer accepts the response

// fast_mult: combinational 4x4 unsigned multiply with an 8-bit result.
// Ports: a, b operands; p product.
module fast_mult (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = {4'b0000, a} * {4'b0000, b};
endmodule

// State table
//   state | meaning
//   IDLE  | searching for a requester from rr_ptr upward; grant is combinational
//   MUL   | registered operands drive the multiplier; product captured on exit
//   RESP  | response presented; held stable until resp_ready
module mult_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [4*N-1:0] req_lhs,
  input  logic [4*N-1:0] req_rhs,
  output logic [N-1:0]   req_ready,
  output logic           resp_valid,
  output logic [IDW-1:0] resp_id,
  output logic [7:0]     resp_data,
  input  logic           resp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] id_q;
  logic [3:0]     lhs_q, rhs_q;
  logic [7:0]     resp_data_q;
  logic [7:0]     prod;

  logic [IDW-1:0] cand;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] rr_next;
  logic           win_found;
  logic [3:0]     lhs_sel, rhs_sel;

  // Walk the offsets from the far end down to zero so that the candidate
  // closest to rr_ptr is the last one written and therefore wins.
  always_comb begin : rr_search
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr_q) + k) % N);
      if (req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin : grant_mux
    req_ready = '0;
    lhs_sel   = '0;
    rhs_sel   = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == IDW'(i)) begin
        lhs_sel = req_lhs[4*i +: 4];
        rhs_sel = req_rhs[4*i +: 4];
        if (state_q == IDLE && win_found) begin
          req_ready[i] = 1'b1;
        end
      end
    end
    rr_next = (win_idx == IDW'(N - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = MUL;
      MUL:     state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      id_q        <= '0;
      lhs_q       <= '0;
      rhs_q       <= '0;
      resp_data_q <= '0;
    end else begin
      if (state_q == IDLE && win_found) begin
        lhs_q    <= lhs_sel;
        rhs_q    <= rhs_sel;
        id_q     <= win_idx;
        rr_ptr_q <= rr_next;
      end
      if (state_q == MUL) begin
        resp_data_q <= prod;
      end
    end
  end

  fast_mult u_fast_mult (
    .a (lhs_q),
    .b (rhs_q),
    .p (prod)
  );

  // All response outputs come straight from flops.
  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_lhs;
  logic [15:0] req_rhs;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [7:0]  resp_data;
  logic        resp_ready;

  logic [3:0] lhs_a [4];
  logic [3:0] rhs_a [4];
  logic [3:0] pend;

  int checks = 0;
  int errors = 0;

  assign req_lhs = {lhs_a[3], lhs_a[2], lhs_a[1], lhs_a[0]};
  assign req_rhs = {rhs_a[3], rhs_a[2], rhs_a[1], rhs_a[0]};

  mult_arbiter #(.N(4), .IDW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_lhs    (req_lhs),
    .req_rhs    (req_rhs),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_ready (resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [3:0] l, input logic [3:0] r);
    lhs_a[i] = l;
    rhs_a[i] = r;
  endtask

  // Called just after a negedge while the arbiter is idle with resp_ready = 1.
  // Presents pend, expects requester g granted, then one MUL cycle, one RESP
  // cycle, and a return to IDLE: exactly three cycles per transaction.
  task automatic run_one(input int g, input logic [7:0] exp_d, input string tag);
    req_valid = pend;
    #1;
    chk({tag, " grant"}, req_ready, 32'(4'b0001 << g));
    @(negedge clk);
    pend[g]   = 1'b0;
    req_valid = pend;
    #1;
    chk({tag, " mul ready"}, req_ready, 0);
    chk({tag, " mul valid"}, resp_valid, 0);
    @(negedge clk);
    chk({tag, " resp valid"}, resp_valid, 1);
    chk({tag, " resp id"}, resp_id, g);
    chk({tag, " resp data"}, resp_data, exp_d);
    @(negedge clk);
    chk({tag, " done"}, resp_valid, 0);
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    pend       = '0;
    for (int i = 0; i < 4; i++) set_ops(i, 4'd0, 4'd0);

    @(negedge clk);
    @(negedge clk);
    chk("rst ready", req_ready, 0);
    chk("rst valid", resp_valid, 0);
    chk("rst id", resp_id, 0);
    chk("rst data", resp_data, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle no req", req_ready, 0);

    // single request
    set_ops(0, 4'd2, 4'd3);
    pend = 4'b0001;
    run_one(0, 8'h06, "single");

    // corner values on requester 3
    set_ops(3, 4'd15, 4'd15);
    pend = 4'b1000;
    run_one(3, 8'hE1, "c15x15");
    set_ops(3, 4'd0, 4'd9);
    pend = 4'b1000;
    run_one(3, 8'h00, "c0x9");
    set_ops(3, 4'd1, 4'd15);
    pend = 4'b1000;
    run_one(3, 8'h0F, "c1x15");

    // contention, pointer back at 0
    for (int i = 0; i < 4; i++) set_ops(i, 4'(i + 1), 4'(i + 1));
    pend = 4'b1111;
    run_one(0, 8'h01, "cont0");
    run_one(1, 8'h04, "cont1");
    run_one(2, 8'h09, "cont2");
    run_one(3, 8'h10, "cont3");

    // round-robin resume: after 2, requester 3 goes before 0
    set_ops(2, 4'd5, 4'd3);
    set_ops(3, 4'd7, 4'd7);
    set_ops(0, 4'd6, 4'd9);
    pend = 4'b0100;
    run_one(2, 8'h0F, "rr2");
    pend = 4'b1001;
    run_one(3, 8'h31, "rr3");
    run_one(0, 8'h36, "rr0");

    // backpressure on requester 1, others waiting during RESP
    set_ops(1, 4'd12, 4'd11);
    resp_ready = 1'b0;
    req_valid  = 4'b0010;
    #1;
    chk("bp grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'b0101;
    #1;
    chk("bp mul ready", req_ready, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp hold valid", resp_valid, 1);
      chk("bp hold id", resp_id, 1);
      chk("bp hold data", resp_data, 8'h84);
      chk("bp hold ready", req_ready, 0);
    end
    @(negedge clk);
    chk("bp still valid", resp_valid, 1);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp accepted", resp_valid, 0);
    chk("bp next grant", req_ready, 4'b0100);
    req_valid = '0;

    // reset while in MUL
    set_ops(2, 4'd3, 4'd5);
    req_valid = 4'b0100;
    #1;
    chk("rm grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    #2;
    reset = 1'b0;
    #1;
    chk("rm ready", req_ready, 0);
    chk("rm valid", resp_valid, 0);
    chk("rm id", resp_id, 0);
    chk("rm data", resp_data, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rm no resp", resp_valid, 0);
    end
    for (int i = 0; i < 4; i++) set_ops(i, 4'd1, 4'd1);
    pend = 4'b1111;
    run_one(0, 8'h01, "rm after");
    req_valid = '0;

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
